// File: rtl/jtexterm_rom_arb_if.sv
// Signal bundle between the Exterm ROM requesters, the ROM arbiter and one SDRAM bank read port.
// The arbiter takes the slave view; the ROM/SDRAM side (or a bench) takes the master view.
interface jtexterm_rom_arb_if;
  logic        downloading;

  logic        main_cs;
  logic [16:0] main_addr;
  logic [7:0]  main_data;
  logic        main_ok;

  logic        sub_cs;
  logic [15:0] sub_addr;
  logic [7:0]  sub_data;
  logic        sub_ok;

  logic        gfx_cs;
  logic [19:0] gfx_addr;
  logic [31:0] gfx_data;
  logic        gfx_ok;

  logic [21:0] ba_addr;
  logic        ba_rd;
  logic        ba_ack;
  logic        ba_dok;
  logic        ba_rdy;
  logic [15:0] data_read;

  modport slave (
    input  downloading,
    input  main_cs, main_addr, sub_cs, sub_addr, gfx_cs, gfx_addr,
    input  ba_ack, ba_dok, ba_rdy, data_read,
    output main_data, main_ok, sub_data, sub_ok, gfx_data, gfx_ok,
    output ba_addr, ba_rd
  );

  modport master (
    output downloading,
    output main_cs, main_addr, sub_cs, sub_addr, gfx_cs, gfx_addr,
    output ba_ack, ba_dok, ba_rdy, data_read,
    input  main_data, main_ok, sub_data, sub_ok, gfx_data, gfx_ok,
    input  ba_addr, ba_rd
  );
endinterface

// File: rtl/jtexterm_rom_arb.sv
// Round-robin arbiter sharing one SDRAM bank read port between main, sub and gfx ROM requesters.
// Each requester keeps a one-word tag, so repeated reads of the same SDRAM word hit without an access.
module jtexterm_rom_arb #(
  parameter logic [21:0] MAIN_OFFSET = 22'h0,
  parameter logic [21:0] SUB_OFFSET  = 22'h10000,
  parameter logic [21:0] GFX_OFFSET  = 22'h20000
) (
  input  logic                clk,
  input  logic                rstn,
  jtexterm_rom_arb_if.slave   bus
);

  localparam int NREQ = 3;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t      r_state, w_state_next;
  logic [21:0] r_tag [NREQ];
  logic [NREQ-1:0] r_tag_valid;
  logic [15:0] r_main_word;
  logic [15:0] r_sub_word;
  logic [31:0] r_gfx_word;
  logic [1:0]  r_grant;
  logic [1:0]  r_rr_next;
  logic        r_word_cnt;
  logic        r_ba_rd;
  logic [21:0] r_ba_addr;

  logic [21:0]     w_addr [NREQ];
  logic [NREQ-1:0] w_cs;
  logic [NREQ-1:0] w_hit;
  logic [NREQ-1:0] w_miss;
  logic            w_grant_en;
  logic [1:0]      w_grant_idx;
  logic            w_grant_fire;
  logic            w_ack_fire;
  logic            w_dok_fire;
  logic            w_rdy_fire;

  // Requester index reached by stepping 'step' places forward in main -> sub -> gfx order.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, step};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign w_addr[0] = {6'd0, bus.main_addr[16:1]} + MAIN_OFFSET;
  assign w_addr[1] = {7'd0, bus.sub_addr[15:1]} + SUB_OFFSET;
  assign w_addr[2] = {1'b0, bus.gfx_addr, 1'b0} + GFX_OFFSET;
  assign w_cs      = {bus.gfx_cs, bus.sub_cs, bus.main_cs};

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_hit[gi]  = w_cs[gi] & r_tag_valid[gi] & (r_tag[gi] == w_addr[gi]);
      assign w_miss[gi] = w_cs[gi] & ~w_hit[gi];
    end
  endgenerate

  // Scan farthest-first so the nearest missing requester after the pointer wins.
  always_comb begin
    w_grant_en  = 1'b0;
    w_grant_idx = r_rr_next;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_miss[rr_idx(r_rr_next, 2'(k))]) begin
        w_grant_en  = 1'b1;
        w_grant_idx = rr_idx(r_rr_next, 2'(k));
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_fire = 1'b0;
    w_ack_fire   = 1'b0;
    w_dok_fire   = 1'b0;
    w_rdy_fire   = 1'b0;
    if (bus.downloading) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_en) begin
            w_grant_fire = 1'b1;
            w_state_next = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.ba_ack) begin
            w_ack_fire   = 1'b1;
            w_state_next = WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          w_dok_fire = bus.ba_dok;
          if (bus.ba_rdy) begin
            w_rdy_fire   = 1'b1;
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_tag_valid <= '0;
      r_main_word <= '0;
      r_sub_word  <= '0;
      r_gfx_word  <= '0;
      r_grant     <= 2'd0;
      r_rr_next   <= 2'd0;
      r_word_cnt  <= 1'b0;
      r_ba_rd     <= 1'b0;
      r_ba_addr   <= '0;
      for (int i = 0; i < NREQ; i++) r_tag[i] <= '0;
    end else begin
      r_state <= w_state_next;
      if (bus.downloading) begin
        r_ba_rd     <= 1'b0;
        r_tag_valid <= '0;
      end else begin
        // r_ba_addr doubles as the captured word address written into the tag on completion.
        if (w_grant_fire) begin
          r_grant                  <= w_grant_idx;
          r_ba_addr                <= w_addr[w_grant_idx];
          r_ba_rd                  <= 1'b1;
          r_tag_valid[w_grant_idx] <= 1'b0;
          r_word_cnt               <= 1'b0;
          r_rr_next                <= rr_idx(w_grant_idx, 2'd1);
        end
        if (w_ack_fire) r_ba_rd <= 1'b0;
        if (w_dok_fire) begin
          case (r_grant)
            2'd0:    r_main_word <= bus.data_read;
            2'd1:    r_sub_word  <= bus.data_read;
            default: begin
              if (r_word_cnt) r_gfx_word[31:16] <= bus.data_read;
              else            r_gfx_word[15:0]  <= bus.data_read;
              r_word_cnt <= 1'b1;
            end
          endcase
        end
        if (w_rdy_fire) begin
          r_tag[r_grant]       <= r_ba_addr;
          r_tag_valid[r_grant] <= 1'b1;
        end
      end
    end
  end

  assign bus.main_ok   = w_hit[0];
  assign bus.sub_ok    = w_hit[1];
  assign bus.gfx_ok    = w_hit[2];
  assign bus.main_data = bus.main_addr[0] ? r_main_word[15:8] : r_main_word[7:0];
  assign bus.sub_data  = bus.sub_addr[0]  ? r_sub_word[15:8]  : r_sub_word[7:0];
  assign bus.gfx_data  = r_gfx_word;
  assign bus.ba_addr   = r_ba_addr;
  assign bus.ba_rd     = r_ba_rd;

endmodule

// File: tb/tb_jtexterm_rom_arb.sv
// Bench for jtexterm_rom_arb: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a transaction-level model of tags, grants and the bank handshake.
`timescale 1ns/1ps
module tb_jtexterm_rom_arb;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  jtexterm_rom_arb_if bus();

  jtexterm_rom_arb dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Responder controls
  logic        rnd_en = 1'b0;
  logic        hold_ack = 1'b0;
  int          data_delay = 0;
  logic        ovr_en = 1'b1;
  logic [15:0] ovr_w0 = 16'h0;
  logic [15:0] ovr_w1 = 16'h0;

  // Model state
  logic [21:0] m_tag [3];
  logic [2:0]  m_valid;
  logic [31:0] m_word [3];
  int          m_ptr;
  logic        m_busy, m_acked;
  int          m_req, m_nw;
  logic [21:0] m_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] waddr(input int r);
    logic [31:0] a;
    case (r)
      0:       a = 32'(bus.main_addr) / 2;
      1:       a = 32'(bus.sub_addr) / 2 + 32'h10000;
      default: a = 32'(bus.gfx_addr) * 2 + 32'h20000;
    endcase
    return a[21:0];
  endfunction

  function automatic logic cs_of(input int r);
    return (r == 0) ? bus.main_cs : (r == 1) ? bus.sub_cs : bus.gfx_cs;
  endfunction

  function automatic logic ok_of(input int r);
    return (r == 0) ? bus.main_ok : (r == 1) ? bus.sub_ok : bus.gfx_ok;
  endfunction

  function automatic logic [31:0] data_of(input int r);
    return (r == 0) ? 32'(bus.main_data) : (r == 1) ? 32'(bus.sub_data) : bus.gfx_data;
  endfunction

  function automatic logic [31:0] exp_data(input int r);
    logic odd;
    odd = (r == 0) ? bus.main_addr[0] : bus.sub_addr[0];
    if (r == 2) return m_word[2];
    return odd ? 32'(m_word[r][15:8]) : 32'(m_word[r][7:0]);
  endfunction

  function automatic logic [15:0] word_for(input logic [21:0] a, input int idx);
    if (ovr_en) return (idx == 0) ? ovr_w0 : ovr_w1;
    return a[15:0] ^ {a[21:16], 10'h0} ^ ((idx == 0) ? 16'h3C3C : 16'h5A5A);
  endfunction

  task automatic model_reset();
    m_valid = 3'b000;
    m_ptr   = 0;
    m_busy  = 1'b0;
    m_acked = 1'b0;
    m_req   = 0;
    m_nw    = 0;
    m_addr  = '0;
    for (int i = 0; i < 3; i++) begin
      m_tag[i]  = '0;
      m_word[i] = '0;
    end
  endtask

  // One clock edge of the arbiter as a transaction: pick, request, collect, retire.
  task automatic model_step();
    int r;
    if (bus.downloading) begin
      m_busy  = 1'b0;
      m_valid = 3'b000;
      return;
    end
    if (!m_busy) begin
      for (int k = 0; k < 3; k++) begin
        r = (m_ptr + k) % 3;
        if (cs_of(r) && !(m_valid[r] && m_tag[r] == waddr(r))) begin
          m_busy     = 1'b1;
          m_acked    = 1'b0;
          m_req      = r;
          m_addr     = waddr(r);
          m_nw       = 0;
          m_valid[r] = 1'b0;
          m_ptr      = (r + 1) % 3;
          break;
        end
      end
    end else if (!m_acked) begin
      if (bus.ba_ack) m_acked = 1'b1;
    end else begin
      if (bus.ba_dok) begin
        if (m_req == 2 && m_nw > 0) m_word[2][31:16] = bus.data_read;
        else                        m_word[m_req][15:0] = bus.data_read;
        m_nw++;
      end
      if (bus.ba_rdy) begin
        m_tag[m_req]   = m_addr;
        m_valid[m_req] = 1'b1;
        m_busy         = 1'b0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else       model_step();
    end
  end

  // Compare process: every negedge, all outputs against the model.
  initial begin
    logic eo;
    forever begin
      @(negedge clk);
      for (int r = 0; r < 3; r++) begin
        eo = cs_of(r) && m_valid[r] && (m_tag[r] == waddr(r));
        chk($sformatf("model ok%0d", r), 32'(ok_of(r)), 32'(eo));
        if (eo) chk($sformatf("model data%0d", r), data_of(r), exp_data(r));
      end
      chk("model ba_rd", 32'(bus.ba_rd), 32'(m_busy && !m_acked));
      if (m_busy && !m_acked) chk("model ba_addr", 32'(bus.ba_addr), 32'(m_addr));
    end
  end

  // SDRAM bank responder
  initial begin
    int          phase, wt, idx, nw;
    logic [21:0] a;
    phase = 0; wt = 0; idx = 0; nw = 1; a = '0;
    bus.ba_ack = 1'b0; bus.ba_dok = 1'b0; bus.ba_rdy = 1'b0; bus.data_read = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ba_ack    = 1'b0;
      bus.ba_dok    = 1'b0;
      bus.ba_rdy    = 1'b0;
      bus.data_read = 16'($urandom);
      if (!rstn) begin
        phase = 0;
      end else if (phase == 0) begin
        if (bus.ba_rd && !hold_ack && (!rnd_en || $urandom_range(0, 2) != 0)) begin
          bus.ba_ack = 1'b1;
          phase = 2;
          a     = bus.ba_addr;
          nw    = (bus.ba_addr >= 22'h20000) ? 2 : 1;
          idx   = 0;
          wt    = rnd_en ? int'($urandom_range(0, 2)) : data_delay;
        end
      end else if (phase == 2) begin
        if (wt > 0) wt--;
        else if (!rnd_en || $urandom_range(0, 1) == 1) begin
          bus.ba_dok    = 1'b1;
          bus.data_read = word_for(a, idx);
          idx++;
          if (idx == nw) begin
            if (!rnd_en || $urandom_range(0, 1) == 1) begin
              bus.ba_rdy = 1'b1;
              phase = 0;
            end else phase = 3;
          end
        end
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          bus.ba_rdy = 1'b1;
          phase = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (at negedges) until the selected output reaches lvl; a timeout counts as a failure.
  task automatic wait_for(input int sel, input logic lvl, input int lim, input string nm);
    logic v;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      case (sel)
        0:       v = bus.ba_rd;
        1:       v = bus.main_ok;
        2:       v = bus.gfx_ok;
        default: v = bus.sub_ok;
      endcase
      if (v === lvl) return;
    end
    checks++;
    errors++;
    $display("FAIL %s timeout after %0d cycles, required level %0b", nm, lim, lvl);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] rises [3];
    logic [16:0] mpool [4];
    logic [15:0] spool [4];
    logic [19:0] gpool [4];
    int nrise, okcnt, dlcnt;
    logic prev;

    mpool = '{17'h00000, 17'h00001, 17'h0A5F2, 17'h1FFFF};
    spool = '{16'h0000, 16'h0001, 16'h7FFE, 16'hFFFF};
    gpool = '{20'h00000, 20'h00010, 20'hFFFFF, 20'h12345};

    rstn = 1'b0;
    bus.downloading = 1'b0;
    bus.main_cs = 1'b0; bus.main_addr = '0;
    bus.sub_cs  = 1'b0; bus.sub_addr  = '0;
    bus.gfx_cs  = 1'b0; bus.gfx_addr  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset ba_rd", 32'(bus.ba_rd), 32'h0);
    chk("reset ba_addr", 32'(bus.ba_addr), 32'h0);
    chk("reset main_ok", 32'(bus.main_ok), 32'h0);

    // Main miss then same-word hit on the other byte
    step();
    ovr_w0 = 16'hABCD;
    bus.main_cs = 1'b1; bus.main_addr = 17'h00003;
    wait_for(0, 1'b1, 10, "t1 ba_rd");
    chk("t1 ba_addr", 32'(bus.ba_addr), 32'h000001);
    wait_for(1, 1'b1, 20, "t1 main_ok");
    chk("t1 main_data", 32'(bus.main_data), 32'hAB);
    step();
    bus.main_addr = 17'h00002;
    @(negedge clk);
    chk("t1 hit main_ok", 32'(bus.main_ok), 32'h1);
    chk("t1 hit main_data", 32'(bus.main_data), 32'hCD);
    chk("t1 hit no ba_rd", 32'(bus.ba_rd), 32'h0);

    // Two-word gfx access
    step();
    bus.main_cs = 1'b0;
    ovr_w0 = 16'h1111; ovr_w1 = 16'h2222;
    bus.gfx_cs = 1'b1; bus.gfx_addr = 20'h00010;
    wait_for(0, 1'b1, 10, "t2 ba_rd");
    chk("t2 ba_addr", 32'(bus.ba_addr), 32'h020020);
    wait_for(2, 1'b1, 20, "t2 gfx_ok");
    chk("t2 gfx_data", bus.gfx_data, 32'h22221111);

    // Three simultaneous misses: grant order main, sub, gfx
    step();
    ovr_en = 1'b0;
    bus.main_cs = 1'b1; bus.main_addr = 17'h00200;
    bus.sub_cs  = 1'b1; bus.sub_addr  = 16'h0004;
    bus.gfx_addr = 20'h00020;
    nrise = 0;
    prev = bus.ba_rd;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (bus.ba_rd && !prev) begin
        if (nrise < 3) rises[nrise] = bus.ba_addr;
        nrise++;
      end
      prev = bus.ba_rd;
    end
    chk("t3 rise count", 32'(nrise), 32'd3);
    if (nrise >= 3) begin
      chk("t3 grant0 main", 32'(rises[0]), 32'h000100);
      chk("t3 grant1 sub", 32'(rises[1]), 32'h010002);
      chk("t3 grant2 gfx", 32'(rises[2]), 32'h020040);
    end
    chk("t3 all ok", {29'd0, bus.gfx_ok, bus.sub_ok, bus.main_ok}, 32'h7);

    // Ack withheld for 10 cycles
    step();
    hold_ack = 1'b1;
    bus.main_addr = 17'h00400;
    wait_for(0, 1'b1, 10, "t4 ba_rd");
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("t4 hold ba_rd", 32'(bus.ba_rd), 32'h1);
      chk("t4 hold ba_addr", 32'(bus.ba_addr), 32'h000200);
    end
    step();
    hold_ack = 1'b0;
    wait_for(0, 1'b0, 6, "t4 ba_rd drop");
    wait_for(1, 1'b1, 20, "t4 main_ok");

    // Address change while data is pending
    step();
    data_delay = 4;
    bus.main_addr = 17'h00000;
    wait_for(0, 1'b1, 10, "t5 ba_rd");
    chk("t5 ba_addr", 32'(bus.ba_addr), 32'h000000);
    wait_for(0, 1'b0, 10, "t5 ack");
    step();
    bus.main_addr = 17'h00100;
    okcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.main_ok) okcnt++;
      if (bus.ba_rd) break;
    end
    chk("t5 main_ok stayed 0", 32'(okcnt), 32'd0);
    chk("t5 reissue ba_addr", 32'(bus.ba_addr), 32'h000080);
    wait_for(1, 1'b1, 20, "t5 main_ok");

    // Download pulse during gfx data phase
    step();
    bus.main_cs = 1'b0; bus.sub_cs = 1'b0;
    data_delay = 3;
    bus.gfx_addr = 20'h00030;
    wait_for(0, 1'b1, 10, "t6 ba_rd");
    wait_for(0, 1'b0, 10, "t6 ack");
    step();
    bus.downloading = 1'b1;
    step();
    @(negedge clk);
    chk("t6 dl gfx_ok", 32'(bus.gfx_ok), 32'h0);
    chk("t6 dl ba_rd", 32'(bus.ba_rd), 32'h0);
    step();
    bus.downloading = 1'b0;
    wait_for(0, 1'b1, 10, "t6 reissue");
    chk("t6 reissue ba_addr", 32'(bus.ba_addr), 32'h020060);
    wait_for(2, 1'b1, 40, "t6 gfx_ok");

    // Randomized traffic
    rnd_en = 1'b1;
    dlcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(0, 5) == 0) bus.main_cs = ~bus.main_cs;
      if ($urandom_range(0, 5) == 0) bus.sub_cs  = ~bus.sub_cs;
      if ($urandom_range(0, 5) == 0) bus.gfx_cs  = ~bus.gfx_cs;
      if ($urandom_range(0, 5) == 0) bus.main_addr = mpool[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) bus.sub_addr  = spool[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) bus.gfx_addr  = gpool[$urandom_range(0, 3)];
      if (dlcnt > 0) dlcnt--;
      else if ($urandom_range(0, 199) == 0) dlcnt = int'($urandom_range(1, 3));
      bus.downloading = (dlcnt > 0);
    end

    // Reset asserted during an access
    step();
    rnd_en = 1'b0;
    data_delay = 5;
    bus.downloading = 1'b0;
    bus.sub_cs = 1'b0; bus.gfx_cs = 1'b0;
    bus.main_cs = 1'b1; bus.main_addr = 17'h01000;
    wait_for(0, 1'b1, 30, "t8 ba_rd");
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("t8 reset ba_rd", 32'(bus.ba_rd), 32'h0);
    chk("t8 reset main_ok", 32'(bus.main_ok), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("t8 after ok", {29'd0, bus.gfx_ok, bus.sub_ok, bus.main_ok}, 32'h0);
    wait_for(1, 1'b1, 40, "t8 recover main_ok");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
